// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port word memory among NUM_REQ requesters.
// Ownership of each accepted access rides a LATENCY-deep pipe so responses return to their issuer.
module mem_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS),
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / BYTE_WIDTH,
  parameter int unsigned IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_w_en_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_w_data_i,
  input  logic [NUM_REQ*BE_WIDTH-1:0]   req_b_en_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_r_data_o,
  output logic                          mem_req_o,
  output logic                          mem_w_en_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_w_data_o,
  output logic [BE_WIDTH-1:0]           mem_b_en_o,
  input  logic [DATA_WIDTH-1:0]         mem_r_data_i
);

  localparam logic [IDX_WIDTH:0]   NUM_REQ_W = (IDX_WIDTH + 1)'(NUM_REQ);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [BE_WIDTH-1:0]   ben_arr   [NUM_REQ];

  logic [IDX_WIDTH-1:0]  rr_q;
  logic [IDX_WIDTH-1:0]  rr_d;
  logic                  grant_vld;
  logic [IDX_WIDTH-1:0]  grant_idx;
  logic [IDX_WIDTH:0]    cand_sum;
  logic [IDX_WIDTH-1:0]  cand_idx;
  logic                  hs;
  logic                  rsp_vld;
  logic [IDX_WIDTH-1:0]  rsp_idx;

  // Per-requester unpacking plus one-hot decode of grant and response owner.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi]    = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi]   = req_w_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign ben_arr[gi]     = req_b_en_i[gi*BE_WIDTH +: BE_WIDTH];
    assign req_ready_o[gi] = grant_vld && (grant_idx == IDX_WIDTH'(gi));
    assign rsp_valid_o[gi] = rsp_vld && (rsp_idx == IDX_WIDTH'(gi));
  end

  // First valid requester at or after rr_q, wrapping modulo NUM_REQ (also for non power-of-two).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand_sum = {1'b0, rr_q} + (IDX_WIDTH + 1)'(k);
      if (cand_sum >= NUM_REQ_W) begin
        cand_sum = cand_sum - NUM_REQ_W;
      end
      cand_idx = cand_sum[IDX_WIDTH-1:0];
      if (!grant_vld && req_valid_i[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign hs = grant_vld;

  always_comb begin
    mem_req_o    = 1'b0;
    mem_w_en_o   = 1'b0;
    mem_addr_o   = '0;
    mem_w_data_o = '0;
    mem_b_en_o   = '0;
    if (hs) begin
      mem_req_o    = 1'b1;
      mem_w_en_o   = req_w_en_i[grant_idx];
      mem_addr_o   = addr_arr[grant_idx];
      mem_w_data_o = wdata_arr[grant_idx];
      mem_b_en_o   = ben_arr[grant_idx];
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (hs) begin
      rr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  if (LATENCY == 0) begin : g_lat0
    assign rsp_vld = hs;
    assign rsp_idx = grant_idx;
  end else begin : g_pipe
    logic                 stage_vld_q [LATENCY];
    logic                 stage_vld_d [LATENCY];
    logic [IDX_WIDTH-1:0] stage_idx_q [LATENCY];
    logic [IDX_WIDTH-1:0] stage_idx_d [LATENCY];

    // Writes are tracked too so they receive a completion pulse.
    always_comb begin
      stage_vld_d[0] = hs;
      stage_idx_d[0] = grant_idx;
      for (int s = 1; s < int'(LATENCY); s++) begin
        stage_vld_d[s] = stage_vld_q[s-1];
        stage_idx_d[s] = stage_idx_q[s-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s < int'(LATENCY); s++) begin
          stage_vld_q[s] <= 1'b0;
          stage_idx_q[s] <= '0;
        end
      end else begin
        for (int s = 0; s < int'(LATENCY); s++) begin
          stage_vld_q[s] <= stage_vld_d[s];
          stage_idx_q[s] <= stage_idx_d[s];
        end
      end
    end

    assign rsp_vld = stage_vld_q[LATENCY-1];
    assign rsp_idx = stage_idx_q[LATENCY-1];
  end

  assign rsp_r_data_o = rsp_vld ? mem_r_data_i : '0;

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port word memory among NUM_REQ requesters.
- Each requester has a valid/ready request channel and a response channel. The arbiter issues at most one memory access per cycle.
- It tracks which requester owns each in-flight access across the memory read latency, and routes read data back to that requester.
- It sits between the core/DMA masters and the memory macro.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- NUM_WORDS, 256, memory depth in words
- DATA_WIDTH, 32, word width in bits
- BYTE_WIDTH, 8, bits per byte lane
- LATENCY, 1, memory read latency in cycles (0..3); must match the attached memory
- ADDR_WIDTH, $clog2(NUM_WORDS), derived; do not override
- BE_WIDTH, DATA_WIDTH/BYTE_WIDTH, derived; byte-enable width
- IDX_WIDTH, max(1,$clog2(NUM_REQ)), derived

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  NUM_REQ  per-requester request valid
- req_ready_o  output  NUM_REQ  per-requester grant/accept
- req_w_en_i  input  NUM_REQ  per-requester write enable
- req_addr_i  input  NUM_REQ*ADDR_WIDTH  packed word addresses; requester i at [i*ADDR_WIDTH+:ADDR_WIDTH]
- req_w_data_i  input  NUM_REQ*DATA_WIDTH  packed write data
- req_b_en_i  input  NUM_REQ*BE_WIDTH  packed byte enables
- rsp_valid_o  output  NUM_REQ  one-hot response strobe
- rsp_r_data_o  output  DATA_WIDTH  read data, shared by all requesters; qualified by rsp_valid_o
- mem_req_o  output  1  memory request
- mem_w_en_o  output  1  memory write enable
- mem_addr_o  output  ADDR_WIDTH  memory address
- mem_w_data_o  output  DATA_WIDTH  memory write data
- mem_b_en_o  output  BE_WIDTH  memory byte enables
- mem_r_data_i  input  DATA_WIDTH  memory read data, valid LATENCY cycles after a read request

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Arbitration:
  - The round-robin pointer rr_q (IDX_WIDTH) marks the highest-priority requester. Reset value is 0.
  - The grant is combinational: the first i with req_valid_i[i]=1, searching i = rr_q, rr_q+1, …, wrapping modulo NUM_REQ.
- Request handshake:
  - req_ready_o is one-hot (or zero) and equals the grant. A handshake occurs when req_valid_i[g] and req_ready_o[g] are both 1.
  - req_ready_o[i]=0 whenever req_valid_i[i]=0.
  - Requesters must hold valid and payload stable until accepted.
- Memory drive:
  - On a handshake: mem_req_o=1 and mem_w_en_o, mem_addr_o, mem_w_data_o, mem_b_en_o come from the granted requester, in the same cycle (combinational).
  - With no handshake: mem_req_o=0 and all other mem_* outputs are 0.
- Pointer update: on a handshake with granted index g, rr_q <= (g+1) mod NUM_REQ. Otherwise rr_q holds.
- Ownership tracking:
  - A LATENCY-stage shift register carries {valid, idx} per stage. It captures {1, g} on every handshake (reads and writes) and {0, x} otherwise.
  - All stages reset to invalid.
- Response:
  - rsp_valid_o[idx] pulses for exactly one cycle, LATENCY cycles after the handshake cycle.
  - With LATENCY=0 the pulse is in the handshake cycle, combinationally.
  - Writes also get this pulse, as a completion ack.
  - rsp_r_data_o = mem_r_data_i whenever any rsp_valid_o bit is set, else 0. It is meaningful only for reads.
- Throughput and ordering: one access per cycle, fully pipelined, no bubbles. Responses return in acceptance order.
- Reset values: req_ready_o=0 (combinational from valid), rsp_valid_o=0, rsp_r_data_o=0, all mem_* outputs 0.
- Boundary conditions:
  - Single active requester: granted every cycle regardless of rr_q.
  - All requesters active: grants rotate 0,1,…,NUM_REQ-1,0 and so on. No requester waits more than NUM_REQ-1 grants.
  - rr_q wraps from NUM_REQ-1 to 0.
  - A requester may issue a new request in the same cycle its previous response returns.
  - Reset asserted mid-operation: in-flight stages are discarded and no response is issued for them. rr_q returns to 0 and outputs go to reset values immediately (asynchronously).

Test Plan:
- Reset, then idle: all req_valid_i=0 -> mem_req_o=0, rsp_valid_o=0, rr_q=0.
- NUM_REQ=4, LATENCY=1, requesters 0..3 all hold valid reads at addresses 0x10..0x13 (memory preloaded with 0xA0..0xA3):
  - grants occur on cycles 0,1,2,3 in order 0,1,2,3;
  - rsp_valid_o = 0001, 0010, 0100, 1000 on cycles 1..4;
  - rsp_r_data_o = 0xA0..0xA3.
- Round-robin fairness: requesters 1 and 3 both continuously valid, rr_q=0 -> grants alternate 1,3,1,3. After 8 cycles each requester has exactly 4 grants.
- Byte-masked write:
  - requester 2 writes 0xDEADBEEF to address 0x05 with b_en=4'b0101 over initial value 0 -> rsp_valid_o[2] pulses one cycle later;
  - a subsequent read by requester 0 returns 0x00AD00EF.
- LATENCY=0 build: requester 1 reads address 0x07 holding 0x55 -> rsp_valid_o[1]=1 and rsp_r_data_o=0x55 in the same cycle as req_ready_o[1].
- Reset mid-flight: LATENCY=2, requester 0 is granted a read, then rst_ni is pulled low in the next cycle -> no rsp_valid_o pulse ever appears. After release, rr_q=0 and the first grant goes to the lowest-index valid requester.
